// File: rtl/uart_rx_framer_pkg.sv
// Shared definitions for the 8N1 UART receive framer: FSM encoding, default
// bit period and the layout of the 16-bit status word.
package uart_rx_framer_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 139;  // 16 MHz / 115200

    localparam int STATUS_FRAME_ERR_BIT = 0;
    localparam int STATUS_OVERRUN_BIT   = 1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_BREAKWAIT = 3'd4
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_framer_if.sv
// Byte handshake between the framer and its consumer (RX FIFO or command decoder).
interface uart_rx_framer_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_framer_bit_sampler.sv
// Two-flop synchroniser on the raw line plus a 3-tap majority vote over the
// current and two previous synchronised samples.
module uart_rx_framer_bit_sampler
    import uart_rx_framer_pkg::*;
(
    input  logic clk,
    input  logic rst_ni,
    input  logic rx_i,
    output logic rx_s_o,
    output logic voted_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic [1:0] hist_q;

    // Everything resets to the idle line level so no false start follows reset.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 2'b11;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            hist_q  <= {hist_q[0], sync2_q};
        end
    end

    assign rx_s_o  = sync2_q;
    assign voted_o = maj3(sync2_q, hist_q[0], hist_q[1]);

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 UART receive framer: start-bit validation, mid-bit majority sampling,
// stop-bit check and a single-byte holding register on a valid/ready port.
module uart_rx_framer
    import uart_rx_framer_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,  // must be >= 8
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                    clk,
    input  logic                    rst_ni,
    input  logic                    rx_i,
    uart_rx_framer_if.master        rx_byte,
    input  logic                    clear_err_i,
    output logic                    frame_err_o,
    output logic                    overrun_o,
    output logic                    busy_o,
    output logic [15:0]             status_o
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;
    logic voted;

    uart_rx_framer_bit_sampler u_sampler (
        .clk     (clk),
        .rst_ni  (rst_ni),
        .rx_i    (rx_i),
        .rx_s_o  (rx_s),
        .voted_o (voted)
    );

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic start_centre;
    logic bit_centre;
    logic byte_done;
    logic frame_bad;
    logic overrun_evt;

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // The vote is complete one clock after the nominal centre, hence the
    // decision points sit at HALF_BIT and CLKS_PER_BIT-1 rather than one earlier.
    always_comb begin
        busy_o       = (state_q != ST_IDLE);
        start_centre = (state_q == ST_START) && (cnt_q == HALF_CNT);
        bit_centre   = ((state_q == ST_DATA) || (state_q == ST_STOP)) && (cnt_q == BIT_END);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (start_centre) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = voted ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_centre) begin
                    cnt_d   = '0;
                    shreg_d = {voted, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_centre) begin
                    cnt_d = '0;
                    if (voted) begin
                        byte_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = ST_BREAKWAIT;
                    end
                end
            end
            ST_BREAKWAIT: begin
                // A held-low line (break) must not be mistaken for a new start.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A byte completing in the same cycle as a pop replaces the popped one.
    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        overrun_evt = 1'b0;
        if (byte_done) begin
            if (!valid_q || rx_byte.ready) begin
                valid_d = 1'b1;
                data_d  = shreg_q;
            end else begin
                overrun_evt = 1'b1;
            end
        end else if (valid_q && rx_byte.ready) begin
            valid_d = 1'b0;
        end
        overrun_d   = clear_err_i ? 1'b0 : (overrun_q | overrun_evt);
        frame_err_d = frame_bad;
    end

    always_comb begin
        status_o                       = '0;
        status_o[STATUS_FRAME_ERR_BIT] = frame_err_q;
        status_o[STATUS_OVERRUN_BIT]   = overrun_q;
    end

    assign rx_byte.data  = data_q;
    assign rx_byte.valid = valid_q;
    assign frame_err_o   = frame_err_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer: directed scenarios plus random frames, checked each
// cycle against an edge-arithmetic model of the receiver.
module tb_uart_rx_framer;
    import uart_rx_framer_pkg::*;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 9 * CPB + HALF + 3;   // RX start edge to valid, in clocks

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        clear_err = 1'b0;
    logic        frame_err, overrun, busy;
    logic [15:0] status;

    uart_rx_framer_if bus();

    uart_rx_framer #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_ni      (rst_n),
        .rx_i        (rx),
        .rx_byte     (bus.master),
        .clear_err_i (clear_err),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
        .busy_o      (busy),
        .status_o    (status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int last_rst = 0;
    bit rx_hist [0:65535];

    // model state
    int         m_mode = 0;   // 0 idle line, 1 inside a frame, 2 waiting for break end
    int         m_start = 0;
    logic [7:0] m_sh = '0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data = '0;
    logic       m_overrun = 1'b0;
    logic       m_fe = 1'b0;

    // DUT-side monitors used by the literal checks
    int         rise_count = 0;
    int         rise_edge = 0;
    int         valid_cycles = 0;
    int         fe_count = 0;
    logic [7:0] last_byte = '0;
    logic       prev_valid = 1'b0;

    // stimulus control
    bit rand_mode = 1'b0;
    bit ready_base = 1'b1;
    int pulse_edge = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // synchronised line value seen at edge x (line is two edges late, idle after reset)
    function automatic bit s_at(input int x);
        return (x - 2 > last_rst) ? rx_hist[x - 2] : 1'b1;
    endfunction

    function automatic bit vote(input int e);
        int n;
        n = int'(s_at(e)) + int'(s_at(e - 1)) + int'(s_at(e - 2));
        return n >= 2;
    endfunction

    always begin
        int         rel, k;
        bit         done, ovr;
        logic       m_busy;
        logic [15:0] exp_status;
        @(posedge clk);
        edge_cnt++;
        rx_hist[edge_cnt] = rx;
        if (!rst_n) begin
            m_mode = 0; m_valid = 1'b0; m_data = '0; m_overrun = 1'b0; m_fe = 1'b0;
            last_rst = edge_cnt;
        end else begin
            done = 1'b0; ovr = 1'b0; m_fe = 1'b0;
            case (m_mode)
                0: if (!s_at(edge_cnt)) begin m_mode = 1; m_start = edge_cnt; end
                1: begin
                    rel = edge_cnt - m_start;
                    if (rel == HALF + 1) begin
                        if (vote(edge_cnt)) m_mode = 0;
                    end else if (rel > HALF + 1 && (rel - HALF - 1) % CPB == 0) begin
                        k = (rel - HALF - 1) / CPB - 1;
                        if (k < 8) m_sh[k] = vote(edge_cnt);
                        else if (vote(edge_cnt)) begin done = 1'b1; m_mode = 0; end
                        else begin m_fe = 1'b1; m_mode = 2; end
                    end
                end
                default: if (s_at(edge_cnt)) m_mode = 0;
            endcase
            if (done) begin
                if (!m_valid || bus.ready) begin m_valid = 1'b1; m_data = m_sh; end
                else ovr = 1'b1;
            end else if (m_valid && bus.ready) begin
                m_valid = 1'b0;
            end
            m_overrun = clear_err ? 1'b0 : (m_overrun | ovr);
        end
        m_busy = (m_mode != 0);
        exp_status = '0;
        exp_status[STATUS_FRAME_ERR_BIT] = m_fe;
        exp_status[STATUS_OVERRUN_BIT]   = m_overrun;

        @(negedge clk);
        checks++;
        if ({bus.valid, bus.data, busy, frame_err, overrun, status} !==
            {m_valid, m_data, m_busy, m_fe, m_overrun, exp_status}) begin
            errors++;
            $display("FAIL outputs@edge%0d: got v=%b d=%h busy=%b ferr=%b ovr=%b st=%h, expected v=%b d=%h busy=%b ferr=%b ovr=%b st=%h",
                     edge_cnt, bus.valid, bus.data, busy, frame_err, overrun, status,
                     m_valid, m_data, m_busy, m_fe, m_overrun, exp_status);
        end
        if (bus.valid && !prev_valid) begin
            rise_count++;
            rise_edge = edge_cnt;
            last_byte = bus.data;
            $display("rx byte 0x%h delivered at edge %0d", bus.data, edge_cnt);
        end
        if (bus.valid === 1'b1) valid_cycles++;
        if (frame_err === 1'b1) fe_count++;
        prev_valid = bus.valid;
    end

    task automatic tick();
        @(negedge clk);
        if (rand_mode) begin
            bus.ready = 1'($urandom_range(0, 1));
            clear_err = ($urandom_range(0, 31) == 0);
        end else begin
            bus.ready = ready_base | (edge_cnt + 1 == pulse_edge);
        end
    endtask

    task automatic drive_bits(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            rx = v;
        end
    endtask

    // prel > 0 raises ready for exactly the edge prel clocks after the start edge
    task automatic send(input logic [7:0] b, input logic stop_bit, input int prel, output int e0);
        tick();
        rx = 1'b0;
        e0 = edge_cnt + 1;
        if (prel > 0) pulse_edge = e0 + prel;
        drive_bits(1'b0, CPB - 1);
        for (int i = 0; i < 8; i++) drive_bits(b[i], CPB);
        drive_bits(stop_bit, CPB);
    endtask

    initial begin
        int e0, rc, fc, vc;
        logic [7:0] b;
        bit bad;
        bus.ready = 1'b1;
        drive_bits(1'b1, 3);
        rst_n = 1'b1;
        drive_bits(1'b1, 4);
        #1;
        check("reset_valid", 32'(bus.valid), 32'd0);
        check("reset_data", 32'(bus.data), 32'h00);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_flags", 32'({frame_err, overrun}), 32'd0);

        // single byte, consumer always ready
        vc = valid_cycles; fc = fe_count;
        send(8'hA5, 1'b1, 0, e0);
        drive_bits(1'b1, 20);
        #1;
        check("a5_data", 32'(last_byte), 32'hA5);
        check("a5_latency", 32'(rise_edge - e0), 32'(LAT));
        check("a5_latency_lit", 32'(rise_edge - e0), 32'd155);
        check("a5_valid_width", 32'(valid_cycles - vc), 32'd1);
        check("a5_no_flags", 32'({fe_count - fc, 32'(overrun)}), 32'd0);

        // one-clock glitch on the idle line
        rc = rise_count; fc = fe_count;
        drive_bits(1'b0, 1);
        drive_bits(1'b1, HALF + 4);
        #1;
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_no_valid", 32'(rise_count - rc), 32'd0);
        check("glitch_no_ferr", 32'(fe_count - fc), 32'd0);

        // bad stop bit followed by a break, then a good byte
        rc = rise_count; fc = fe_count;
        send(8'h3C, 1'b0, 0, e0);
        drive_bits(1'b0, 40);
        #1;
        check("break_ferr_pulses", 32'(fe_count - fc), 32'd1);
        check("break_busy", 32'(busy), 32'd1);
        check("break_no_valid", 32'(rise_count - rc), 32'd0);
        drive_bits(1'b1, 20);
        #1;
        check("break_release_busy", 32'(busy), 32'd0);
        send(8'h55, 1'b1, 0, e0);
        drive_bits(1'b1, 20);
        #1;
        check("after_break_data", 32'(last_byte), 32'h55);

        // overrun with consumer stalled
        ready_base = 1'b0;
        send(8'h11, 1'b1, 0, e0);
        send(8'h22, 1'b1, 0, e0);
        drive_bits(1'b1, 20);
        #1;
        check("ovr_data", 32'(bus.data), 32'h11);
        check("ovr_valid", 32'(bus.valid), 32'd1);
        check("ovr_flag", 32'(overrun), 32'd1);
        ready_base = 1'b1;
        drive_bits(1'b1, 2);
        #1;
        check("ovr_consumed", 32'(bus.valid), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);
        clear_err = 1'b1;
        drive_bits(1'b1, 1);
        clear_err = 1'b0;
        drive_bits(1'b1, 2);
        #1;
        check("ovr_cleared", 32'(overrun), 32'd0);

        // pop coinciding with the next completion
        ready_base = 1'b0;
        send(8'h11, 1'b1, 0, e0);
        send(8'h22, 1'b1, LAT, e0);
        drive_bits(1'b1, 10);
        #1;
        check("swap_data", 32'(bus.data), 32'h22);
        check("swap_valid", 32'(bus.valid), 32'd1);
        check("swap_no_ovr", 32'(overrun), 32'd0);
        ready_base = 1'b1;
        drive_bits(1'b1, 5);

        // reset in the middle of data bit 4 of 0xFF
        rc = rise_count; fc = fe_count;
        drive_bits(1'b0, CPB);
        drive_bits(1'b1, 4 * CPB + HALF);
        rst_n = 1'b0;
        drive_bits(1'b1, 2);
        rst_n = 1'b1;
        #1;
        check("midrst_valid", 32'(bus.valid), 32'd0);
        check("midrst_data", 32'(bus.data), 32'h00);
        check("midrst_busy", 32'(busy), 32'd0);
        drive_bits(1'b1, 6 * CPB);
        #1;
        check("midrst_quiet", 32'({rise_count - rc, fe_count - fc, 32'(overrun)}), 32'd0);
        send(8'h81, 1'b1, 0, e0);
        drive_bits(1'b1, 20);
        #1;
        check("midrst_next_data", 32'(last_byte), 32'h81);

        // random traffic, consumer and clear randomised, checked by the model
        rand_mode = 1'b1;
        for (int f = 0; f < 40; f++) begin
            b = 8'($urandom);
            bad = ($urandom_range(0, 9) == 0);
            send(b, !bad, 0, e0);
            if (bad) drive_bits(1'b0, $urandom_range(0, 30));
            drive_bits(1'b1, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20));
            if ($urandom_range(0, 7) == 0) begin
                drive_bits(1'b0, $urandom_range(1, 3));
                drive_bits(1'b1, 20);
            end
        end
        rand_mode = 1'b0;
        ready_base = 1'b1;
        clear_err = 1'b0;
        drive_bits(1'b1, 300);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
